bsg_fifo_1r1w_latch_array: RTL and testbench

Parametrised single-clock FIFO whose storage is an array of transparent-low latches rather than flops. It generalises the single-stage transparent-high latch in width and depth and adds valid/ready flow control, wrap-around pointers and an occupancy count. It serves as a low-area elastic buffer between pipeline stages in the same clock domain, where a flop-based FIFO's area is the limiting cost.

---
 rtl/bsg_fifo_1r1w_latch_array.sv | 156 +++++++++++++++
 tb/tb_bsg_fifo_1r1w_latch_array.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/bsg_fifo_1r1w_latch_array.sv
// Single-clock FIFO with transparent-low latch storage and valid/ready flow control.
// Latency: data accepted on an edge is visible on v_o/data_o right after that edge.
// Backpressure: ready_o drops when full; yumi_i dequeues the head, and is ignored when empty.
//
// Ports:
//   clk_i    - clock; flops update on the rising edge, latches are open while clk_i is low
//   reset_i  - asynchronous active-high reset
//   data_i   - enqueue data          v_i   - enqueue valid (accepted when v_i & ready_o)
//   ready_o  - not full              v_o   - not empty
//   data_o   - head data, 0 when v_o=0
//   yumi_i   - dequeue head (only meaningful when v_o=1)
//   count_o  - occupancy 0..els_p
//
// Build option: define BSG_FIFO_LATCH_ARRAY_USE_FLOPS_EN to replace the latch array with a
// rising-edge flop array written straight from data_i (no staging, no bypass). Port-level
// cycle behaviour is the same in both builds.
//
// Parameters: width_p >= 1, els_p a power of two >= 2.

module bsg_fifo_1r1w_latch_array #(
  parameter int width_p = 32,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       v_i,
  output logic                       ready_o,
  output logic [width_p-1:0]         data_o,
  output logic                       v_o,
  input  logic                       yumi_i,
  output logic [$clog2(els_p+1)-1:0] count_o
);

  localparam int ptr_w = $clog2(els_p);
  localparam int cnt_w = $clog2(els_p + 1);

  logic [ptr_w-1:0]   wptr_q, wptr_d;
  logic [ptr_w-1:0]   rptr_q, rptr_d;
  logic [cnt_w-1:0]   count_q, count_d;
  logic               enq, deq;
  logic [width_p-1:0] mem_rd [els_p];
  logic [width_p-1:0] head_dat;

  // Status outputs decode flops only, so v_i/yumi_i never reach them combinationally.
  assign ready_o = (count_q != cnt_w'(els_p));
  assign v_o     = (count_q != '0);
  assign count_o = count_q;

  // A yumi on an empty FIFO is masked so it cannot move rptr or count.
  assign enq = v_i & ready_o;
  assign deq = yumi_i & v_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (enq) wptr_d = wptr_q + ptr_w'(1);
    if (deq) rptr_d = rptr_q + ptr_w'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + cnt_w'(1);
      2'b01:   count_d = count_q - cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef BSG_FIFO_LATCH_ARRAY_USE_FLOPS_EN

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define what is valid.
  for (genvar i = 0; i < els_p; i++) begin : g_ent
    logic [width_p-1:0] ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (enq && (wptr_q == ptr_w'(i))) ent_d = data_i;
    end

    always_ff @(posedge clk_i) begin
      ent_q <= ent_d;
    end

    assign mem_rd[i] = ent_q;
  end

  assign head_dat = mem_rd[rptr_q];

`else

  // Write staging: the enqueue edge captures data/address here, and the selected latch
  // copies it during the following low phase.
  logic [width_p-1:0] wdata_q, wdata_d;
  logic [ptr_w-1:0]   waddr_q, waddr_d;
  logic               we_q, we_d;

  always_comb begin
    // Holding wdata/waddr when idle keeps the latch inputs quiet between writes.
    wdata_d = enq ? data_i : wdata_q;
    waddr_d = enq ? wptr_q : waddr_q;
    we_d    = enq;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      wdata_q <= '0;
      waddr_q <= '0;
      we_q    <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      waddr_q <= waddr_d;
      we_q    <= we_d;
    end
  end

  for (genvar i = 0; i < els_p; i++) begin : g_ent
    logic               ent_en;
    logic [width_p-1:0] ent_l;

    // we_q/waddr_q only change on the rising edge, while ~clk_i is already low, so the
    // AND with ~clk_i cannot glitch open. Reset clears we_q and closes an open latch,
    // abandoning that write.
    assign ent_en = ~clk_i & we_q & (waddr_q == ptr_w'(i));

    always_latch begin
      if (ent_en) ent_l <= wdata_q;
    end

    assign mem_rd[i] = ent_l;
  end

  // During the high phase after an enqueue the target latch is still closed, so a
  // freshly written head must come from the staging register.
  assign head_dat = (we_q && (waddr_q == rptr_q)) ? wdata_q : mem_rd[rptr_q];

`endif

  assign data_o = v_o ? head_dat : '0;

endmodule

// File: tb/tb_bsg_fifo_1r1w_latch_array.sv
module tb_bsg_fifo_1r1w_latch_array;

  logic        clk_i;
  logic        reset_i;
  logic [31:0] data_i;
  logic        v_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic        v_o;
  logic        yumi_i;
  logic [2:0]  count_o;

  int total = 0;
  int bad   = 0;

  bsg_fifo_1r1w_latch_array #(.width_p(32), .els_p(4)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (data_i),
    .v_i     (v_i),
    .ready_o (ready_o),
    .data_o  (data_o),
    .v_o     (v_o),
    .yumi_i  (yumi_i),
    .count_o (count_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_st(input string tag, input int cnt, input logic v, input logic rdy,
                        input logic [31:0] dat);
    chk({tag, ".count"}, 32'(count_o), 32'(cnt));
    chk({tag, ".v"},     32'(v_o),     32'(v));
    chk({tag, ".ready"}, 32'(ready_o), 32'(rdy));
    chk({tag, ".data"},  data_o,       dat);
  endtask

  initial begin
    reset_i = 1'b1;
    v_i     = 1'b0;
    yumi_i  = 1'b0;
    data_i  = '0;
    #2;
    chk_st("reset", 0, 1'b0, 1'b1, 32'h0);
    #10;
    reset_i = 1'b0;

    // Fill to full, one extra enqueue must be dropped, then drain in order.
    v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_i = 32'hA0 + 32'(k);
      tick();
    end
    data_i = 32'hFF;
    tick();
    v_i = 1'b0;
    chk_st("fill", 4, 1'b1, 1'b0, 32'hA0);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d", k), data_o, 32'hA0 + 32'(k));
      yumi_i = 1'b1;
      tick();
    end
    yumi_i = 1'b0;
    chk_st("drained", 0, 1'b0, 1'b1, 32'h0);

    // Bypass: visible in the high phase right after the accepting edge.
    v_i    = 1'b1;
    data_i = 32'h1234_5678;
    tick();
    v_i    = 1'b0;
    data_i = 32'hDEAD_BEEF;
    chk_st("bypass_hi", 1, 1'b1, 1'b1, 32'h1234_5678);
    #5;
    chk("bypass_lo.data", data_o, 32'h1234_5678);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk_st("bypass_deq", 0, 1'b0, 1'b1, 32'h0);

    // Streaming: one pre-load, then enqueue+dequeue every cycle across several wraps.
    v_i    = 1'b1;
    data_i = 32'd100;
    tick();
    for (int c = 1; c <= 20; c++) begin
      data_i = 32'd100 + 32'(c);
      yumi_i = 1'b1;
      chk($sformatf("stream%0d.data", c), data_o, 32'd100 + 32'(c - 1));
      chk($sformatf("stream%0d.count", c), 32'(count_o), 32'd1);
      tick();
    end
    v_i    = 1'b0;
    yumi_i = 1'b0;
    chk_st("stream_end", 1, 1'b1, 1'b1, 32'd120);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk_st("stream_empty", 0, 1'b0, 1'b1, 32'h0);

    // Full with simultaneous yumi: only the dequeue happens.
    v_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data_i = 32'hB0 + 32'(k);
      tick();
    end
    data_i = 32'hB4;
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;
    chk_st("full_yumi", 3, 1'b1, 1'b1, 32'hB1);
    tick();
    v_i = 1'b0;
    chk_st("full_again", 4, 1'b1, 1'b0, 32'hB1);
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("fdrain%0d", k), data_o, 32'hB0 + 32'(k));
      yumi_i = 1'b1;
      tick();
    end
    yumi_i = 1'b0;
    chk_st("fdrained", 0, 1'b0, 1'b1, 32'h0);

    // Illegal yumi while empty must not disturb pointers or count.
    yumi_i = 1'b1;
    tick();
    tick();
    yumi_i = 1'b0;
    chk_st("illegal_yumi", 0, 1'b0, 1'b1, 32'h0);
    v_i    = 1'b1;
    data_i = 32'h55;
    tick();
    v_i    = 1'b0;
    chk_st("after_illegal", 1, 1'b1, 1'b1, 32'h55);
    tick();
    chk("after_illegal_latched.data", data_o, 32'h55);
    yumi_i = 1'b1;
    tick();
    yumi_i = 1'b0;

    // Reset mid-cycle with three entries and a latch write in progress.
    v_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_i = 32'hC0 + 32'(k);
      tick();
    end
    v_i = 1'b0;
    chk_st("pre_reset", 3, 1'b1, 1'b1, 32'hC0);
    #5;
    reset_i = 1'b1;
    #1;
    chk_st("mid_reset", 0, 1'b0, 1'b1, 32'h0);
    #2;
    reset_i = 1'b0;
    v_i     = 1'b1;
    data_i  = 32'h77;
    tick();
    v_i     = 1'b0;
    tick();
    chk_st("post_reset", 1, 1'b1, 1'b1, 32'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
